// File: rtl/mmio_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: FSM encoding,
// register offsets and the STATUS word layout.
`timescale 1ns/1ps
package mmio_uart_tx_pkg;

    // FSM state encoding
    localparam int unsigned STATE_W   = 3;
    localparam logic [2:0]  ST_IDLE   = 3'd0;
    localparam logic [2:0]  ST_START  = 3'd1;
    localparam logic [2:0]  ST_DATA   = 3'd2;
    localparam logic [2:0]  ST_PARITY = 3'd3;
    localparam logic [2:0]  ST_STOP   = 3'd4;

    // Register offsets within the 8-byte window
    localparam logic [2:0]  DATA_OFS   = 3'd0;
    localparam logic [2:0]  STATUS_OFS = 3'd4;

    // STATUS bit that clears the sticky overflow flag when written as 1
    localparam int unsigned STS_OVF_BIT = 3;

    // FIFO occupancy field width (depth is at most 8)
    localparam int unsigned COUNT_W = 4;
    localparam int unsigned BAUD_W  = 16;

    // STATUS read word
    typedef struct packed {
        logic [23:0]        rsvd;
        logic [COUNT_W-1:0] count;
        logic               overflow;
        logic               busy;
        logic               empty;
        logic               full;
    } status_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Core data-memory port as seen by the UART: store strobe/address/data from
// the core, decode hit and read data back to the core's ReadData mux.
`timescale 1ns/1ps
interface mmio_uart_tx_if;
    logic        MemWrite;
    logic [31:0] Mem_WrAddr;
    logic [31:0] Mem_WrData;
    logic        hit;
    logic [31:0] rd_data;

    modport master (
        output MemWrite, Mem_WrAddr, Mem_WrData,
        input  hit, rd_data
    );

    modport slave (
        input  MemWrite, Mem_WrAddr, Mem_WrData,
        output hit, rd_data
    );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock byte FIFO with occupancy count; a push into a full FIFO is
// accepted only when a pop happens on the same edge.
`timescale 1ns/1ps
module mmio_uart_tx_sync_fifo
    import mmio_uart_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_push,
    input  logic [WIDTH-1:0]   i_wdata,
    input  logic               i_pop,
    output logic [WIDTH-1:0]   o_rdata,
    output logic               o_full,
    output logic               o_empty,
    output logic [COUNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [COUNT_W-1:0] r_count;
    logic               w_pop_ok;
    logic               w_push_ok;

    assign o_full    = (r_count == COUNT_W'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Storage array; contents are don't-care while the entry is unoccupied
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + COUNT_W'(1);
                2'b01:   r_count <= r_count - COUNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped UART transmitter on the core's data-memory port.
// DATA at BASE_ADDR (write pushes a byte), STATUS at BASE_ADDR+4.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (11 bit-times per frame).
`timescale 1ns/1ps
module mmio_uart_tx
    import mmio_uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    mmio_uart_tx_if.slave  bus,
    output logic           tx
);

    localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLK_DIV - 1);

    logic [STATE_W-1:0] r_state;
    logic [BAUD_W-1:0]  r_baud;
    logic [2:0]         r_bit_idx;
    logic [7:0]         r_shift;
    logic               r_parity;
    logic               r_tx;
    logic               r_overflow;

    logic [STATE_W-1:0] w_state_nxt;
    logic [BAUD_W-1:0]  w_baud_nxt;
    logic [2:0]         w_bit_nxt;
    logic [7:0]         w_shift_nxt;
    logic               w_parity_nxt;
    logic               w_tx_nxt;
    logic               w_wrap;
    logic               w_pop;

    logic               w_hit;
    logic               w_sel_data;
    logic               w_sel_status;
    logic               w_push;
    logic               w_ovf_clr;
    logic               w_ovf_set;
    logic [7:0]         w_fifo_rdata;
    logic               w_full;
    logic               w_empty;
    logic [COUNT_W-1:0] w_count;
    status_t            w_status;
    logic               w_unused;

    // Address decode: 8-byte window, word-aligned accesses only
    assign w_hit        = (bus.Mem_WrAddr[31:3] == BASE_ADDR[31:3]) && (bus.Mem_WrAddr[1:0] == 2'b00);
    assign w_sel_data   = w_hit && (bus.Mem_WrAddr[2:0] == DATA_OFS);
    assign w_sel_status = w_hit && (bus.Mem_WrAddr[2:0] == STATUS_OFS);
    assign w_push       = bus.MemWrite && w_sel_data;
    assign w_ovf_clr    = bus.MemWrite && w_sel_status && bus.Mem_WrData[STS_OVF_BIT];
    assign w_ovf_set    = w_push && w_full && !w_pop;
    assign w_unused     = ^bus.Mem_WrData[31:8];

    mmio_uart_tx_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata (bus.Mem_WrData[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // STATUS word and read-data mux back to the core
    always_comb begin
        w_status          = '0;
        w_status.count    = w_count;
        w_status.overflow = r_overflow;
        w_status.busy     = (r_state != ST_IDLE);
        w_status.empty    = w_empty;
        w_status.full     = w_full;
        bus.hit           = w_hit;
        bus.rd_data       = w_sel_status ? 32'(w_status) : 32'h0;
    end

    // Frame FSM next-state: baud counter, bit index, shift register and next tx level
    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud;
        w_bit_nxt    = r_bit_idx;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_pop        = 1'b0;
        w_tx_nxt     = 1'b1;
        w_wrap       = (r_baud == BAUD_MAX);

        if (r_state != ST_IDLE) begin
            w_baud_nxt = w_wrap ? '0 : (r_baud + BAUD_W'(1));
        end

        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_nxt  = w_fifo_rdata;
                    w_parity_nxt = ^w_fifo_rdata;
                    w_baud_nxt   = '0;
                    w_state_nxt  = ST_START;
                end
            end
            ST_START: begin
                if (w_wrap) begin
                    w_bit_nxt   = 3'd0;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_wrap) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_bit_nxt   = r_bit_idx + 3'd1;
                    if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_nxt = ST_PARITY;
`else
                        w_state_nxt = ST_STOP;
`endif
                    end
                end
            end
            ST_PARITY: begin
                if (w_wrap) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_wrap) begin
                    // Back-to-back frames: reload straight into START when data waits
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_nxt  = w_fifo_rdata;
                        w_parity_nxt = ^w_fifo_rdata;
                        w_state_nxt  = ST_START;
                    end else begin
                        w_state_nxt  = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        case (w_state_nxt)
            ST_START:  w_tx_nxt = 1'b0;
            ST_DATA:   w_tx_nxt = w_shift_nxt[0];
            ST_PARITY: w_tx_nxt = w_parity_nxt;
            default:   w_tx_nxt = 1'b1;
        endcase
    end

    // Frame FSM state, datapath and registered tx line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_baud    <= w_baud_nxt;
            r_bit_idx <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_parity  <= w_parity_nxt;
            r_tx      <= w_tx_nxt;
        end
    end

    // Sticky overflow: a dropped byte wins over a simultaneous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (w_ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign tx = r_tx;

endmodule
